// File: rtl/tdm_pkg.sv
// tdm_pkg: shared types and sizing for the TDM demultiplexer.
package tdm_pkg;
  localparam int N_CH_DEF = 8;
  typedef enum logic {HUNT, LOCK} state_e;
  function automatic int slot_w(input int n);
    return $clog2(n);
  endfunction
endpackage

// File: rtl/tdm_slot_ctr.sv
// tdm_slot_ctr: slot index counter; wraps naturally because N_CH is a power of two.
module tdm_slot_ctr
  import tdm_pkg::*;
#(
  parameter  int N_CH   = N_CH_DEF,
  localparam int SLOT_W = slot_w(N_CH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              load0,
  output logic [SLOT_W-1:0] slot,
  output logic              last
);
  logic [SLOT_W-1:0] slot_q, slot_d;
  // a sync sample occupies slot 0, so the next expected slot is 1
  always_comb slot_d = load0 ? SLOT_W'(1) : en ? slot_q + 1'b1 : slot_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) slot_q <= '0;
    else slot_q <= slot_d;
  end
  assign slot = slot_q;
  assign last = slot_q == SLOT_W'(N_CH - 1);
endmodule

// File: rtl/tdm_demux.sv
// tdm_demux: reassembles a serial TDM stream into N_CH-bit parallel frames.
module tdm_demux
  import tdm_pkg::*;
#(
  parameter  int N_CH   = N_CH_DEF,
  localparam int SLOT_W = slot_w(N_CH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              din,
  input  logic              frame_sync,
  output logic [N_CH-1:0]   dout,
  output logic              frame_valid,
  output logic [SLOT_W-1:0] slot,
  output logic              locked,
  output logic              sync_err
);
  state_e            state_q, state_d;
  logic [N_CH-1:0]   shadow_q, shadow_d, dout_q, dout_d;
  logic              fv_q, fv_d, err_q, err_d;
  logic              lock, sync, last, complete;
  assign lock = state_q == LOCK;
  assign sync = en & frame_sync;
  tdm_slot_ctr #(.N_CH(N_CH)) u_ctr (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (en & lock),
    .load0(sync),
    .slot (slot),
    .last (last)
  );
  // a sync arriving on the last slot is a resync and suppresses completion
  assign complete = en & lock & ~frame_sync & last;
  always_comb begin
    state_d  = sync ? LOCK : state_q;
    shadow_d = shadow_q;
    if (en & (lock | frame_sync)) shadow_d[frame_sync ? '0 : slot] = din;
    dout_d   = complete ? {din, shadow_q[N_CH-2:0]} : dout_q;
    fv_d     = complete;
    err_d    = sync & lock & (slot != '0);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= HUNT;
      shadow_q <= '0;
      dout_q   <= '0;
      fv_q     <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      dout_q   <= dout_d;
      fv_q     <= fv_d;
      err_q    <= err_d;
    end
  end
  assign dout        = dout_q;
  assign frame_valid = fv_q;
  assign locked      = lock;
  assign sync_err    = err_q;
endmodule

// File: tb/tb_tdm_demux.sv
// tb_tdm_demux: table vectors, directed sequences and random stimulus against a queue-based model.
module tb_tdm_demux;
  localparam int N = 8;
  logic clk = 0, rst_n = 0, en = 0, din = 0, frame_sync = 0;
  logic [N-1:0] dout;
  logic frame_valid, locked, sync_err;
  logic [2:0] slot;
  int errors = 0, checks = 0, cyc = 0, fv_last = 0, fv_prev = 0, err_cnt = 0, fv_cnt = 0;
  bit m_q[$];
  logic m_locked = 0, m_fv = 0, m_err = 0;
  logic [N-1:0] m_dout = '0;
  typedef struct {
    logic en, fs, d, fv, lk;
    logic [N-1:0] dout;
    int slot;
  } vec_t;
  vec_t tbl[9];

  tdm_demux #(.N_CH(N)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .din(din), .frame_sync(frame_sync),
    .dout(dout), .frame_valid(frame_valid), .slot(slot), .locked(locked), .sync_err(sync_err)
  );

  always #5 clk = ~clk;

  function void chk(string n, logic [31:0] a, logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", n, a, e, cyc);
    end
  endfunction

  function void model_reset();
    m_q.delete();
    m_locked = 0; m_fv = 0; m_err = 0; m_dout = '0;
  endfunction

  function void model_step(logic e, logic fs, logic d);
    m_fv = 0; m_err = 0;
    if (!e) return;
    if (fs) begin
      if (m_locked && m_q.size() != 0) m_err = 1;
      m_locked = 1;
      m_q.delete();
      m_q.push_back(d);
    end else if (m_locked) m_q.push_back(d);
    if (m_q.size() == N) begin
      for (int i = 0; i < N; i++) m_dout[i] = m_q[i];
      m_fv = 1;
      m_q.delete();
    end
  endfunction

  task automatic step(input logic e, input logic fs, input logic d);
    en = e; frame_sync = fs; din = d;
    @(posedge clk);
    #1;
    cyc++;
    model_step(e, fs, d);
    if (frame_valid) begin fv_prev = fv_last; fv_last = cyc; fv_cnt++; end
    if (sync_err) err_cnt++;
    chk("dout", dout, m_dout);
    chk("frame_valid", frame_valid, m_fv);
    chk("sync_err", sync_err, m_err);
    chk("locked", locked, m_locked);
    chk("slot", slot, m_locked ? m_q.size() : 0);
  endtask

  task automatic send_frame(input logic [N-1:0] b, input logic sync);
    for (int i = 0; i < N; i++) step(1, sync && i == 0, b[i]);
  endtask

  initial begin
    logic [N-1:0] pat;
    pat = 8'h6E;
    for (int i = 0; i < N; i++) begin
      tbl[i].en = 1; tbl[i].fs = (i == 0); tbl[i].d = pat[i];
      tbl[i].fv = (i == N - 1); tbl[i].lk = 1;
      tbl[i].dout = (i == N - 1) ? 8'h6E : 8'h00;
      tbl[i].slot = (i + 1) % N;
    end
    tbl[8].en = 0; tbl[8].fs = 1; tbl[8].d = 1; tbl[8].fv = 0; tbl[8].lk = 1;
    tbl[8].dout = 8'h6E; tbl[8].slot = 0;

    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_dout", dout, 0); chk("rst_fv", frame_valid, 0); chk("rst_slot", slot, 0);
    chk("rst_locked", locked, 0); chk("rst_err", sync_err, 0);
    @(negedge clk) rst_n = 1;

    for (int i = 0; i < 10; i++) step(0, $urandom_range(0, 1), $urandom_range(0, 1));

    for (int i = 0; i < 9; i++) begin
      step(tbl[i].en, tbl[i].fs, tbl[i].d);
      chk("tbl_dout", dout, tbl[i].dout);
      chk("tbl_fv", frame_valid, tbl[i].fv);
      chk("tbl_slot", slot, tbl[i].slot);
      chk("tbl_locked", locked, tbl[i].lk);
    end

    err_cnt = 0;
    send_frame(8'h6E, 1);
    send_frame(8'hA5, 0);
    chk("fv_spacing", fv_last - fv_prev, 8);
    chk("dout_A5", dout, 8'hA5);
    chk("no_sync_err", err_cnt, 0);

    pat = 8'h3C;
    for (int i = 0; i < N; i++) begin
      step(1, 0, pat[i]);
      step(0, 1, ~pat[i]);
      chk("slot_hold", slot, (i + 1) % N);
    end
    chk("dout_3C", dout, 8'h3C);

    err_cnt = 0; fv_cnt = 0;
    for (int i = 0; i < 4; i++) step(1, 0, 1);
    send_frame(8'hF0, 1);
    chk("resync_err_cnt", err_cnt, 1);
    chk("resync_fv_cnt", fv_cnt, 1);
    chk("dout_F0", dout, 8'hF0);

    for (int i = 0; i < 6; i++) step(1, 0, i[0]);
    rst_n = 0;
    #1;
    model_reset();
    chk("arst_dout", dout, 0); chk("arst_slot", slot, 0); chk("arst_locked", locked, 0);
    chk("arst_fv", frame_valid, 0); chk("arst_err", sync_err, 0);
    @(negedge clk) rst_n = 1;
    fv_cnt = 0;
    for (int i = 0; i < 12; i++) step(1, 0, $urandom_range(0, 1));
    chk("nosync_fv_cnt", fv_cnt, 0);
    send_frame(8'h81, 1);
    chk("dout_81", dout, 8'h81);

    for (int i = 0; i < 600; i++)
      step($urandom_range(0, 3) != 0, $urandom_range(0, 11) == 0, $urandom_range(0, 1));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/tdm_demux.md
# tdm_demux

Time-division demultiplexer for the receive end of the 8:1 channel mux path. It accepts the one-bit serial stream produced by scanning an 8-input mux through select values 0..7 and a frame marker for slot 0. It reassembles one bit per channel into an 8-bit parallel word and flags each completed frame. It sits directly behind the mux/select generator and feeds parallel consumers.

## Interface
- `N_CH`, default 8: channels per frame; must be a power of two, at least 2.
- `SLOT_W`, default `$clog2(N_CH)` = 3: slot index width; derived, never overridden.
- `clk` input 1: single clock; all state updates on its rising edge.
- `rst_n` input 1: reset, asynchronous and active-low.
- `en` input 1: sample enable; a slot advances only on cycles with `en`=1.
- `din` input 1: serial data bit for the current slot.
- `frame_sync` input 1: qualified by `en`; marks the current `din` as slot 0.
- `dout` output N_CH: last completed frame; bit i carries channel i.
- `frame_valid` output 1: one-cycle pulse when `dout` updates.
- `slot` output SLOT_W: slot index expected for the next enabled sample; mirrors the mux select.
- `locked` output 1: high once a `frame_sync` has been accepted.
- `sync_err` output 1: one-cycle pulse when `frame_sync` arrives at a nonzero expected slot while locked.

## Operation
- States: HUNT (reset state, waiting for the first sync) and LOCK.
- HUNT:
  - `en`=1 with `frame_sync`=0: sample ignored, `slot` holds 0.
  - `en`=1 with `frame_sync`=1: `din` goes to shadow[0], `slot` becomes 1, next state is LOCK.
- LOCK, on each `en`=1 cycle:
  - shadow[slot] gets `din`.
  - `slot` increments and wraps from N_CH-1 to 0.
- Frame completion: the sample written at slot N_CH-1 completes the frame.
  - `dout` gets {`din`, shadow[N_CH-2:0]}.
  - `frame_valid` pulses.
- LOCK, `frame_sync`=1 while expected `slot`=0: normal alignment with no error.
- LOCK, `frame_sync` missing at slot 0: tolerated; the counter flywheels.
- LOCK, `frame_sync`=1 while expected `slot`≠0 (resync):
  - `sync_err` pulses.
  - The partial frame is discarded; no `frame_valid` and `dout` unchanged.
  - The current `din` is taken as slot 0 and `slot` becomes 1.
- `en`=0: all state, `slot` and shadow hold; no pulses; lock is kept. `frame_sync` and `din` are ignored.
- Shadow register is not cleared between frames; every bit is overwritten before use.

## Timing
- Reset values, applied immediately on `rst_n` falling:
  - `dout`=0, `frame_valid`=0, `sync_err`=0, `slot`=0, `locked`=0, state HUNT, shadow=0.
- All outputs are registered.
- Latency: the sample at slot N_CH-1 taken on edge k gives `dout` and `frame_valid`=1 visible after edge k. `frame_valid` drops after edge k+1 unless another frame completes.
- Back-to-back frames with `en` held high: one `frame_valid` every N_CH cycles.
- `sync_err` is registered in the same edge as the resync sample.
- Resync landing when expected `slot` = N_CH-1:
  - The resync wins; no `frame_valid` that cycle.
  - The sample goes to slot 0.
- `locked` rises on the edge that accepts the first sync.
- Reset asserted mid-frame: everything returns to reset values, and the partial frame is lost. After release, a fresh `frame_sync` is required.

## Structure
- Package `tdm_pkg`:
  - `N_CH` default.
  - state enum {HUNT, LOCK}.
  - `SLOT_W` derivation as a function or localparam.
- Sub-module `tdm_slot_ctr` holds the slot counter.
  - Inputs: `clk`, `rst_n`, `en`, `load0`.
  - Outputs: `slot`, `last` (slot==N_CH-1).
  - `load0` forces the next slot to 1 after a sync sample.
- Top level holds the FSM, shadow register, output register and pulse generation.

## Test plan
- Reset, then `en`=0 for 10 cycles -> all outputs 0, `locked`=0, `slot`=0.
- Sync, then stream 8'h6E LSB first (bits 0,1,1,1,0,1,1,0) with `en`=1 -> `dout`=8'h6E, one `frame_valid` pulse the cycle after slot 7, `slot` back to 0, `locked`=1.
- Two consecutive frames 8'h6E then 8'hA5, sync only on the first -> `frame_valid` pulses exactly 8 cycles apart; `dout`=8'hA5 last; `sync_err` never asserts.
- `en` toggled 1/0 every cycle while sending 8'h3C -> `dout`=8'h3C after 8 enabled samples, 16 cycles total; `slot` holds on `en`=0 cycles.
- After syncing, 4 bits, then `frame_sync` with a full frame 8'hF0 -> `sync_err` pulses once, no `frame_valid` for the partial frame, then `dout`=8'hF0.
- `rst_n` asserted after slot 5 of a frame, then released -> outputs 0, `locked`=0. Bits without sync -> no `frame_valid`. A later synced 8'h81 -> `dout`=8'h81.
